// File: rtl/centroid_update_8cen_16bit_pkg.sv
// Shared constants for the centroid update block.
// Defines the centroid/observation width, the centroid count, the field widths
// and the FSM state encoding. Other files in this block import it.
package centroid_update_8cen_16bit_pkg;

  localparam int unsigned CuWidth  = 16;  // centroid and observation width
  localparam int unsigned CuNcen   = 8;   // number of centroids
  localparam int unsigned CuIdxW   = 3;   // centroid index width
  localparam int unsigned CuShiftW = 4;   // learning-rate exponent width
  localparam int unsigned CuHitsW  = 8;   // hit counter width

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRead  = 2'd1,
    StWrite = 2'd2,
    StDone  = 2'd3
  } cu_state_e;

endpackage

// File: rtl/centroid_update_8cen_16bit_if.sv
// Request/response bundle for the centroid update block.
//   in_valid/in_ready : request handshake
//   load, arg, obs, shift : request fields (overwrite flag, centroid index,
//                           observation, learning-rate exponent)
//   done  : one-cycle pulse after the centroid write completes
//   hits  : post-write hit count of the centroid last written
// The master modport drives requests; the slave modport is the update block.
interface centroid_update_8cen_16bit_if
  import centroid_update_8cen_16bit_pkg::*;
();

  logic                in_valid;
  logic                in_ready;
  logic                load;
  logic [CuIdxW-1:0]   arg;
  logic [CuWidth-1:0]  obs;
  logic [CuShiftW-1:0] shift;
  logic                done;
  logic [CuHitsW-1:0]  hits;

  modport master (
    output in_valid, load, arg, obs, shift,
    input  in_ready, done, hits
  );

  modport slave (
    input  in_valid, load, arg, obs, shift,
    output in_ready, done, hits
  );

endinterface

// File: rtl/centroid_step_16bit.sv
// Combinational centroid step.
//   c     : current centroid value
//   obs   : observation
//   shift : learning-rate exponent
//   load  : 1 = overwrite with obs, 0 = learning step
//   new_c : next centroid value
// Learning step is c + floor((obs - c) / 2^shift). The result always lies
// between c and obs inclusive, so no saturation is needed and truncating the
// sum back to WIDTH bits is exact.
module centroid_step_16bit
  import centroid_update_8cen_16bit_pkg::*;
#(
  parameter int unsigned WIDTH = CuWidth
) (
  input  logic [WIDTH-1:0]    c,
  input  logic [WIDTH-1:0]    obs,
  input  logic [CuShiftW-1:0] shift,
  input  logic                load,
  output logic [WIDTH-1:0]    new_c
);

  logic signed [WIDTH:0] diff;
  logic signed [WIDTH:0] step;

  always_comb begin
    diff  = $signed({1'b0, obs}) - $signed({1'b0, c});
    // Arithmetic shift floors toward minus infinity for negative differences.
    step  = diff >>> shift;
    new_c = load ? obs : WIDTH'($unsigned({1'b0, c}) + $unsigned(step));
  end

endmodule

// File: rtl/centroid_update_8cen_16bit.sv
// Centroid update engine for an 8-centroid online k-means style quantiser.
//   clk, rst   : clock, asynchronous active-high reset
//   bus        : request handshake, done pulse and hit count (slave side)
//   c_000..c_111 : registered centroids feeding the argmin comparator
// A request is accepted in IDLE, the selected centroid is read in READ,
// written in WRITE, and done pulses in DONE (3 clocks request-to-done).
module centroid_update_8cen_16bit
  import centroid_update_8cen_16bit_pkg::*;
#(
  parameter int unsigned WIDTH = CuWidth,
  parameter int unsigned NCEN  = CuNcen
) (
  input  logic                         clk,
  input  logic                         rst,
  centroid_update_8cen_16bit_if.slave  bus,
  output logic [WIDTH-1:0]             c_000,
  output logic [WIDTH-1:0]             c_001,
  output logic [WIDTH-1:0]             c_010,
  output logic [WIDTH-1:0]             c_011,
  output logic [WIDTH-1:0]             c_100,
  output logic [WIDTH-1:0]             c_101,
  output logic [WIDTH-1:0]             c_110,
  output logic [WIDTH-1:0]             c_111
);

  localparam logic [CuHitsW-1:0] HitsMax = '1;

  cu_state_e state_q, state_d;

  logic                load_q;
  logic [CuIdxW-1:0]   arg_q;
  logic [WIDTH-1:0]    obs_q;
  logic [CuShiftW-1:0] shift_q;
  logic [WIDTH-1:0]    csel_q;
  logic [WIDTH-1:0]    new_c;

  logic [WIDTH-1:0]   cen_q [NCEN];
  logic [CuHitsW-1:0] hit_q [NCEN];
  logic [CuHitsW-1:0] hits_q;
  logic [CuHitsW-1:0] hit_next;

  logic accept;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = StRead;
      StRead:  state_d = StWrite;
      StWrite: state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs
  always_comb begin
    bus.in_ready = (state_q == StIdle);
    bus.done     = (state_q == StDone);
  end

  assign accept   = bus.in_valid && (state_q == StIdle);
  assign bus.hits = hits_q;

  // Post-write counter value: loads clear it, learning writes saturate at max.
  always_comb begin
    if (load_q) begin
      hit_next = '0;
    end else if (hit_q[arg_q] == HitsMax) begin
      hit_next = HitsMax;
    end else begin
      hit_next = hit_q[arg_q] + 1'b1;
    end
  end

  // Request capture and centroid read
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      load_q  <= 1'b0;
      arg_q   <= '0;
      obs_q   <= '0;
      shift_q <= '0;
      csel_q  <= '0;
    end else begin
      if (accept) begin
        load_q  <= bus.load;
        arg_q   <= bus.arg;
        obs_q   <= bus.obs;
        shift_q <= bus.shift;
      end
      if (state_q == StRead) begin
        csel_q <= cen_q[arg_q];
      end
    end
  end

  // Centroid and hit-counter storage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < int'(NCEN); k++) begin
        cen_q[k] <= WIDTH'(k * 32'h2000);
        hit_q[k] <= '0;
      end
      hits_q <= '0;
    end else if (state_q == StWrite) begin
      cen_q[arg_q] <= new_c;
      hit_q[arg_q] <= hit_next;
      hits_q       <= hit_next;
    end
  end

  centroid_step_16bit #(
    .WIDTH (WIDTH)
  ) u_step (
    .c     (csel_q),
    .obs   (obs_q),
    .shift (shift_q),
    .load  (load_q),
    .new_c (new_c)
  );

  assign c_000 = cen_q[0];
  assign c_001 = cen_q[1];
  assign c_010 = cen_q[2];
  assign c_011 = cen_q[3];
  assign c_100 = cen_q[4];
  assign c_101 = cen_q[5];
  assign c_110 = cen_q[6];
  assign c_111 = cen_q[7];

endmodule

// File: tb/tb_centroid_update_8cen_16bit.sv
// Directed self-checking bench for centroid_update_8cen_16bit.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_centroid_update_8cen_16bit;

  logic clk;
  logic rst;
  logic [15:0] c_000, c_001, c_010, c_011, c_100, c_101, c_110, c_111;

  int tests_run = 0;
  int tests_failed = 0;

  centroid_update_8cen_16bit_if bus ();

  centroid_update_8cen_16bit dut (
    .clk   (clk),
    .rst   (rst),
    .bus   (bus),
    .c_000 (c_000),
    .c_001 (c_001),
    .c_010 (c_010),
    .c_011 (c_011),
    .c_100 (c_100),
    .c_101 (c_101),
    .c_110 (c_110),
    .c_111 (c_111)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    tests_run++;
    assert (observed === expected)
    else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Present one request starting at a falling edge; return after done is seen
  // (or the bound expires) with lat = falling edges from accept to done.
  task automatic send(input logic ld, input logic [2:0] a, input logic [15:0] o,
                      input logic [3:0] sh, output int lat);
    int n;
    bus.in_valid = 1'b1;
    bus.load     = ld;
    bus.arg      = a;
    bus.obs      = o;
    bus.shift    = sh;
    n = 0;
    while (!bus.in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.done && lat < 10) begin
      @(negedge clk);
      lat++;
    end
  endtask

  initial begin
    int lat;
    int done_cnt;
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.load     = 1'b0;
    bus.arg      = '0;
    bus.obs      = '0;
    bus.shift    = '0;
    repeat (3) @(negedge clk);
    check("rst_ready_held", 32'(bus.in_ready), 32'd1);
    rst = 1'b0;
    @(negedge clk);

    // Reset state
    check("rst_c011", 32'(c_011), 32'h6000);
    check("rst_c111", 32'(c_111), 32'hE000);
    check("rst_c000", 32'(c_000), 32'h0000);
    check("rst_ready", 32'(bus.in_ready), 32'd1);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_hits", 32'(bus.hits), 32'd0);

    // Learning update: 0x6000 + (0x1000 >>> 2) = 0x6400
    send(1'b0, 3'd3, 16'h7000, 4'd2, lat);
    check("learn_latency", 32'(lat), 32'd3);
    check("learn_done", 32'(bus.done), 32'd1);
    check("learn_c011", 32'(c_011), 32'h6400);
    check("learn_hits", 32'(bus.hits), 32'd1);
    check("learn_c010", 32'(c_010), 32'h4000);
    check("learn_c100", 32'(c_100), 32'h8000);
    @(negedge clk);
    check("learn_done_fall", 32'(bus.done), 32'd0);
    check("learn_ready_back", 32'(bus.in_ready), 32'd1);
    check("learn_hits_held", 32'(bus.hits), 32'd1);

    // Negative step: preload 0x0010, then floor(-1/16) = -1 -> 0x000F
    send(1'b1, 3'd0, 16'h0010, 4'd0, lat);
    check("load_c000", 32'(c_000), 32'h0010);
    check("load_hits", 32'(bus.hits), 32'd0);
    @(negedge clk);
    send(1'b0, 3'd0, 16'h000F, 4'd4, lat);
    check("neg_c000", 32'(c_000), 32'h000F);
    check("neg_hits", 32'(bus.hits), 32'd1);
    @(negedge clk);

    // Larger negative step: 0x2000 + (-0x1000 >>> 3) = 0x1E00
    send(1'b0, 3'd1, 16'h1000, 4'd3, lat);
    check("neg2_c001", 32'(c_001), 32'h1E00);
    @(negedge clk);

    // shift = 0 lands exactly on obs
    send(1'b0, 3'd2, 16'h1234, 4'd0, lat);
    check("shift0_c010", 32'(c_010), 32'h1234);
    check("shift0_hits", 32'(bus.hits), 32'd1);
    check("shift0_c011", 32'(c_011), 32'h6400);
    @(negedge clk);

    // Busy request: in_valid held, obs changes after the first accept.
    // First: 0x8000 + (-0x3000 >>> 1) = 0x6800; second: 0x6800 + 0x1C00 = 0x8400
    bus.in_valid = 1'b1;
    bus.load     = 1'b0;
    bus.arg      = 3'd4;
    bus.obs      = 16'h5000;
    bus.shift    = 4'd1;
    @(negedge clk);                        // READ
    bus.obs = 16'hA000;
    check("busy_ready_read", 32'(bus.in_ready), 32'd0);
    @(negedge clk);                        // WRITE
    check("busy_c100_prewrite", 32'(c_100), 32'h8000);
    @(negedge clk);                        // DONE
    check("busy_done1", 32'(bus.done), 32'd1);
    check("busy_c100_first", 32'(c_100), 32'h6800);
    check("busy_ready_done", 32'(bus.in_ready), 32'd0);
    @(negedge clk);                        // IDLE, second accepted next edge
    check("busy_ready_idle", 32'(bus.in_ready), 32'd1);
    check("busy_c100_idle", 32'(c_100), 32'h6800);
    @(negedge clk);                        // READ
    bus.in_valid = 1'b0;
    @(negedge clk);                        // WRITE
    @(negedge clk);                        // DONE
    check("busy_done2", 32'(bus.done), 32'd1);
    check("busy_c100_second", 32'(c_100), 32'h8400);
    check("busy_hits", 32'(bus.hits), 32'd2);
    @(negedge clk);

    // Hit saturation on centroid 7, then load clears it
    for (int i = 0; i < 300; i++) begin
      send(1'b0, 3'd7, 16'hE000, 4'd0, lat);
      @(negedge clk);
    end
    check("sat_hits", 32'(bus.hits), 32'd255);
    check("sat_c111", 32'(c_111), 32'hE000);
    send(1'b1, 3'd7, 16'h1357, 4'd5, lat);
    check("sat_load_hits", 32'(bus.hits), 32'd0);
    check("sat_load_c111", 32'(c_111), 32'h1357);
    @(negedge clk);

    // Reset during WRITE: no write, no done, centroids back to reset values
    bus.in_valid = 1'b1;
    bus.load     = 1'b1;
    bus.arg      = 3'd5;
    bus.obs      = 16'hFFFF;
    bus.shift    = 4'd0;
    @(negedge clk);                        // READ
    bus.in_valid = 1'b0;
    @(negedge clk);                        // WRITE
    rst = 1'b1;
    done_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (bus.done) done_cnt++;
    end
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (bus.done) done_cnt++;
    end
    check("midrst_no_done", 32'(done_cnt), 32'd0);
    check("midrst_c101", 32'(c_101), 32'hA000);
    check("midrst_c000", 32'(c_000), 32'h0000);
    check("midrst_c100", 32'(c_100), 32'h8000);
    check("midrst_c111", 32'(c_111), 32'hE000);
    check("midrst_ready", 32'(bus.in_ready), 32'd1);
    check("midrst_hits", 32'(bus.hits), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/centroid_update_8cen_16bit.md
CENTROID_UPDATE_8CEN_16BIT -- requirements
Module: centroid_update_8cen_16bit

Interface
REQ-001 SHALL have parameter WIDTH, default 16, meaning centroid and observation bit width.
REQ-002 SHALL have parameter NCEN, default 8, meaning number of centroids; fixed at 8, giving a 3-bit index.
REQ-003 SHALL have port clk, input, 1, meaning the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1, meaning reset; asynchronous and active-high.
REQ-005 SHALL have port in_valid, input, 1, meaning an update request is presented.
REQ-006 SHALL have port in_ready, output, 1, meaning the block can accept a request.
REQ-007 SHALL have port load, input, 1, meaning overwrite the centroid (1) or learning update (0).
REQ-008 SHALL have port arg, input, 3, meaning winning centroid index from the 8-centroid argmin comparator.
REQ-009 SHALL have port obs, input, 16, meaning unsigned observation value.
REQ-010 SHALL have port shift, input, 4, meaning learning-rate exponent; step is (obs-c)/2^shift.
REQ-011 SHALL have ports c_000..c_111, output, 16 each, meaning registered centroids that feed the comparator directly.
REQ-012 SHALL have port hits, output, 8, meaning the saturating update count of the centroid last written.
REQ-013 SHALL have port done, output, 1, meaning a one-cycle pulse when a write has completed.

Function
REQ-014 SHALL accept a request on a rising edge where in_valid and in_ready are both 1, and SHALL capture load, arg, obs and shift at that edge.
REQ-015 SHALL drive in_ready to 1 only in state IDLE.
REQ-016 SHALL leave a request presented while not in IDLE unaccepted and without effect.
REQ-017 SHALL implement FSM states and transitions as follows:
- IDLE -> READ on accept.
- READ -> WRITE unconditionally.
- WRITE -> DONE unconditionally.
- DONE -> IDLE unconditionally.
REQ-018 SHALL, in READ, register the selected centroid c = c_arg and the 17-bit signed difference d = {0,obs} - {0,c}.
REQ-019 SHALL, in WRITE with load=0, set c_arg := c + (d >>> shift), where >>> is an arithmetic shift (floor).
REQ-020 SHALL, in WRITE with load=1, set c_arg := obs.
REQ-021 SHALL need no saturation: the result lies between c and obs inclusive, and shift=0 yields obs.
REQ-022 SHALL assert done for exactly the one cycle spent in DONE, so the write is visible on c_* before done rises.
REQ-023 SHALL give a request-to-done latency of 3 clocks (accept edge E0, done high after E2).
REQ-024 SHALL, on a learning write, increment the per-centroid hit counter, saturating at 255.
REQ-025 SHALL, on a load write, clear that centroid's hit counter to 0.
REQ-026 SHALL present the written centroid's post-write counter on hits from the DONE cycle until the next write.
REQ-027 SHALL leave the centroids other than c_arg unchanged on every write.

Reset
REQ-028 SHALL, while rst=1, force state IDLE, in_ready=1, done=0, hits=0, all hit counters 0, and c_k = k*16'h2000 (c_000=0x0000 ... c_111=0xE000).
REQ-029 SHALL, on a reset mid-operation, abandon the request with no centroid write and no done pulse.

Structure
REQ-030 SHALL take WIDTH, NCEN and the FSM state encodings (IDLE=0, READ=1, WRITE=2, DONE=3) from the team's shared constants include.
REQ-031 SHALL place the arithmetic of REQ-018 to REQ-021 in one combinational sub-module, centroid_step_16bit (inputs c, obs, shift, load; output new_c).
REQ-032 SHALL keep all other logic (FSM, registers, counters) in the top module.

Verification
REQ-033 SHALL cover reset: after reset release -> c_011=0x6000, in_ready=1, done=0, hits=0.
REQ-034 SHALL cover a learning update: arg=3, obs=0x7000, shift=2, load=0 -> c_011=0x6400, done pulses 3 clocks after accept, hits=1, other centroids unchanged.
REQ-035 SHALL cover a negative step: arg=0 preloaded via load=1 with obs=0x0010, then obs=0x000F, shift=4 -> c_000=0x000F (floor of -1/16 = -1).
REQ-036 SHALL cover a busy request: in_valid held through READ/WRITE/DONE with different obs -> only the first request is applied, the second is accepted in the next IDLE.
REQ-037 SHALL cover hit saturation: 300 learning updates to arg=7 -> hits=255; then load=1 -> hits=0, c_111=obs.
REQ-038 SHALL cover reset mid-operation: rst asserted in WRITE -> no done pulse, c_* return to reset values, in_ready=1.
